fetch_unit: RTL

- Instruction-fetch stage directly upstream of the branch comparator and execute stage.
- Owns the PC, issues one instruction-memory request at a time over a valid/ready request channel, and holds each returned instruction for decode.
- Consumes the taken-branch/jump redirect produced downstream: reloads the PC and squashes or drains any stale fetch.

---
 rtl/fetch_unit_if.sv | 27 ++
 rtl/fetch_unit.sv | 92 +++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, downstream redirect
// and the decode-facing hold register.
interface fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready;

    modport master (
        output imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc, if_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc, if_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, keeps one imem request in flight, holds the
// returned word for decode and absorbs taken-branch redirects.
//
//   state | meaning
//   REQ   | request for r_pc presented to imem
//   WAIT  | request accepted, awaiting its response
//   HOLD  | instruction held for decode
//   DRAIN | a stale response is still owed; drop it on arrival
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus
);
    localparam logic [1:0] S_REQ   = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_inflight_pc;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_instr;

    logic        w_req_hs;
    logic        w_redirect;
    logic        w_rsp;
    logic [31:0] w_redirect_pc;

    assign w_req_hs      = bus.imem_req_valid & bus.imem_req_ready;
    assign w_redirect    = bus.redirect_valid;
    assign w_rsp         = bus.imem_rsp_valid;
    assign w_redirect_pc = {bus.redirect_pc[31:2], 2'b00};

    // Gated by rst_n so no request is visible while reset is held.
    assign bus.imem_req_valid = (r_state == S_REQ) & rst_n;
    assign bus.imem_req_addr  = r_pc;
    assign bus.if_valid       = (r_state == S_HOLD);
    assign bus.if_pc          = r_if_pc;
    assign bus.if_instr       = r_if_instr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_REQ;
            r_pc          <= RESET_PC;
            r_inflight_pc <= RESET_PC;
            r_if_pc       <= RESET_PC;
            r_if_instr    <= NOP_INSTR;
        end else begin
            if (w_redirect) begin
                r_pc <= w_redirect_pc;
            end
            case (r_state)
                S_REQ: begin
                    if (w_req_hs) begin
                        r_inflight_pc <= r_pc;
                        r_state       <= w_redirect ? S_DRAIN : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_redirect) begin
                        r_state <= w_rsp ? S_REQ : S_DRAIN;
                    end else if (w_rsp) begin
                        r_if_instr <= bus.imem_rsp_data;
                        r_if_pc    <= r_inflight_pc;
                        r_pc       <= r_inflight_pc + 32'd4;
                        r_state    <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (w_redirect) begin
                        r_if_instr <= NOP_INSTR;
                        r_state    <= S_REQ;
                    end else if (bus.if_ready) begin
                        r_state <= S_REQ;
                    end
                end
                S_DRAIN: begin
                    // The owed response still retires the drain even if a newer
                    // redirect lands in the same cycle; only the PC is replaced.
                    if (w_rsp) begin
                        r_state <= S_REQ;
                    end
                end
                default: r_state <= S_REQ;
            endcase
        end
    end
endmodule
